mp_add_sequencer: RTL

Multi-precision add sequencer that drives the 16-bit ripple-carry adder core and consumes its result. It sequences an N-word operand stream, least-significant word first. For each word it registers operands and carry-in toward the adder, captures sum and carry-out, and threads the carry into the next word. Operands arrive and results leave through valid/ready handshakes, so a W-bit core adds WORD_W*N-bit numbers.

---
 rtl/mp_add_sequencer_if.sv | 50 +++++
 rtl/mp_add_sequencer.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/mp_add_sequencer_if.sv
// Handshake and adder-core bus for mp_add_sequencer.
// The sequencer connects through the slave modport and its environment
// (operand source, adder core, result sink) through the master modport.
// Optional subtract support is enabled with the MP_ADD_SUB_EN macro.
interface mp_add_sequencer_if #(
    parameter int WORD_W = 16,
    parameter int CNT_W  = 4
);
    logic              start;
    logic [CNT_W-1:0]  nwords;
    logic              cin;
`ifdef MP_ADD_SUB_EN
    logic              sub;
`endif
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_a;
    logic [WORD_W-1:0] in_b;
    logic [WORD_W-1:0] add_a;
    logic [WORD_W-1:0] add_b;
    logic              add_cin;
    logic [WORD_W-1:0] add_sum;
    logic              add_cout;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_sum;
    logic              out_last;
    logic              out_cout;
    logic              busy;

`ifdef MP_ADD_SUB_EN
    modport slave (
        input  start, nwords, cin, sub, in_valid, in_a, in_b, add_sum, add_cout, out_ready,
        output in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_last, out_cout, busy
    );
    modport master (
        output start, nwords, cin, sub, in_valid, in_a, in_b, add_sum, add_cout, out_ready,
        input  in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_last, out_cout, busy
    );
`else
    modport slave (
        input  start, nwords, cin, in_valid, in_a, in_b, add_sum, add_cout, out_ready,
        output in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_last, out_cout, busy
    );
    modport master (
        output start, nwords, cin, in_valid, in_a, in_b, add_sum, add_cout, out_ready,
        input  in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_last, out_cout, busy
    );
`endif
endinterface

// File: rtl/mp_add_sequencer.sv
// Multi-precision add sequencer: streams N operand words (LSW first) through
// an external WORD_W-bit adder core, threading the carry between words.
// Optional feature macro: MP_ADD_SUB_EN (adds bus.sub; computes A-B).
module mp_add_sequencer #(
    parameter int WORD_W    = 16,
    parameter int MAX_WORDS = 8,
    parameter int CNT_W     = 4
) (
    input logic            clk,
    input logic            rst_n,
    mp_add_sequencer_if.slave bus
);

    typedef enum logic [1:0] {IDLE, WAIT, ADD, OUT} state_t;

    state_t            state;
    state_t            next_state;

    logic [CNT_W-1:0]  nwords_q;
    logic [CNT_W-1:0]  idx;
    logic              carry;
    logic [WORD_W-1:0] add_a_q;
    logic [WORD_W-1:0] add_b_q;
    logic              add_cin_q;
    logic [WORD_W-1:0] sum_q;
    logic              last_q;
    logic              cout_q;

    logic              start_ok;
    logic              init_carry;
    logic [WORD_W-1:0] b_word;
    logic              in_ready;
    logic              out_valid;
    logic              busy;

`ifdef MP_ADD_SUB_EN
    logic              sub_q;

    // Operand B inversion and forced initial carry turn the adder into A-B.
    always_comb begin
        init_carry = bus.sub ? 1'b1 : bus.cin;
        b_word     = sub_q ? ~bus.in_b : bus.in_b;
    end
`else
    // Plain addition: operands pass straight through.
    always_comb begin
        init_carry = bus.cin;
        b_word     = bus.in_b;
    end
`endif

    assign start_ok = bus.start && (bus.nwords != '0) && (bus.nwords <= CNT_W'(MAX_WORDS));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and handshake outputs decoded from the current state.
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start_ok) next_state = WAIT;
            end
            WAIT: begin
                in_ready = 1'b1;
                if (bus.in_valid) next_state = ADD;
            end
            ADD: begin
                next_state = OUT;
            end
            OUT: begin
                out_valid = 1'b1;
                if (bus.out_ready) next_state = last_q ? IDLE : WAIT;
            end
            default: next_state = IDLE;
        endcase
    end

    // Datapath: operand/carry registers toward the core and captured results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nwords_q  <= '0;
            idx       <= '0;
            carry     <= 1'b0;
            add_a_q   <= '0;
            add_b_q   <= '0;
            add_cin_q <= 1'b0;
            sum_q     <= '0;
            last_q    <= 1'b0;
            cout_q    <= 1'b0;
`ifdef MP_ADD_SUB_EN
            sub_q     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        nwords_q <= bus.nwords;
                        carry    <= init_carry;
                        idx      <= '0;
`ifdef MP_ADD_SUB_EN
                        sub_q    <= bus.sub;
`endif
                    end
                end
                WAIT: begin
                    if (bus.in_valid) begin
                        add_a_q   <= bus.in_a;
                        add_b_q   <= b_word;
                        add_cin_q <= carry;
                    end
                end
                ADD: begin
                    sum_q  <= bus.add_sum;
                    carry  <= bus.add_cout;
                    last_q <= (idx == nwords_q - CNT_W'(1));
                    cout_q <= bus.add_cout;
                end
                OUT: begin
                    if (bus.out_ready && !last_q) idx <= idx + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.busy      = busy;
    assign bus.add_a     = add_a_q;
    assign bus.add_b     = add_b_q;
    assign bus.add_cin   = add_cin_q;
    assign bus.out_sum   = sum_q;
    assign bus.out_last  = last_q;
    assign bus.out_cout  = cout_q;

endmodule
